// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_TICKS_PER_BIT = 16;
  localparam int unsigned UART_DATA_WIDTH    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module uart_sync #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, DATA_WIDTH bits LSB first, optional parity, stop).
// Define UART_RX_PARITY_EN to insert a parity bit after the data bits; without it
// parity_err is tied low and PARITY_ODD has no effect.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned TICKS_PER_BIT = UART_TICKS_PER_BIT,
  parameter int unsigned DATA_WIDTH    = UART_DATA_WIDTH,
  parameter bit          PARITY_ODD    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  sample_tick,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int unsigned TW = $clog2(TICKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic rx_s;
  logic rx_prev_q;

  uart_rx_state_t          state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    done_q, done_d;
  logic                    ferr_q, ferr_d;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_s;
    end
  end

  // Frame FSM: bit timing, data shifting and end-of-frame reporting.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Only a genuine high-to-low transition starts a frame; a held-low line does not.
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop so a following start edge is caught without a gap.
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = IDLE;
            dout_d  = shift_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised on a tick grid, expected words are
// queued at send time and a monitor checks each rx_done against the queue head.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TPB      = 16;
  localparam int DW       = 8;
  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] dout;
  logic          rx_done;
  logic          frame_err;
  logic          parity_err;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   exp_cnt = 0;
  int   tdiv = 0;

  uart_rx #(
    .TICKS_PER_BIT(TPB),
    .DATA_WIDTH   (DW),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .sample_tick(sample_tick),
    .dout       (dout),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Free-running baud generator: one tick every TICK_DIV clocks.
  always @(posedge clk) begin
    tdiv        <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
    sample_tick <= (tdiv == TICK_DIV - 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every rx_done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rx_done: got dout=0x%0h, expected no frame", dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e.data));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
        check("parity_err", 32'(parity_err), 32'(e.perr));
      end
    end else if (frame_err || parity_err) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_error_pulse: got ferr=%0b perr=%0b, expected 0 without rx_done",
               frame_err, parity_err);
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(TPB);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic ferr, input logic perr);
    exp_q.push_back({d, ferr, perr});
    exp_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b) begin end
`endif
    send_bit(stop_b);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'h0);
    check({tag, "_rx_done"}, 32'(rx_done), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_quiet_outputs("reset");
    rst_n = 1'b1;
    wait_ticks(4);

    // 1. Single frame.
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_ticks(4);

    // 2. Back-to-back with no idle gap.
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_ticks(4);

    // 3. Short low glitch is rejected.
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(6);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_no_done", 32'(done_cnt), 32'(exp_cnt));
    wait_ticks(4);

    // 4. Stop bit low, line held low afterwards (break).
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(2 * 10 * TPB);
    check("break_no_restart", 32'(done_cnt), 32'(exp_cnt));
    check("break_state", 32'(dut.state_q), 32'(IDLE));
    rx_in = 1'b1;
    wait_ticks(20);

    // 5. Reset in the middle of data bit 3.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_ticks(TPB / 2);
    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet_outputs("midframe_reset");
    rst_n = 1'b1;
    wait_ticks(20);
    check("reset_no_done", 32'(done_cnt), 32'(exp_cnt));
    expect_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_ticks(4);

`ifdef UART_RX_PARITY_EN
    // 6. Even parity: correct and corrupted parity bit.
    expect_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_ticks(4);
`endif

    wait_ticks(20);
    check("total_rx_done", 32'(done_cnt), 32'(exp_cnt));
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule : tb_uart_rx
